// File: rtl/operand_gather_pkg.sv
// Shared constants and types for the operand gather block.
package operand_gather_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned QUAD_WORDS = 4;
    localparam int unsigned PTR_W      = 2;

    // Slot index of the word that completes a quad
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUAD_WORDS - 1);

    // Collector state: COLLECT accepts words, HOLD parks a finished quad
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } col_state_e;

endpackage

// File: rtl/operand_gather_out_reg.sv
// Output quad register with valid/ready hold and delivered-quad counter.
module gather_out_reg
    import operand_gather_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [QUAD_WORDS*WIDTH-1:0]   load_data,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              op1,
    output logic [WIDTH-1:0]              op2,
    output logic [WIDTH-1:0]              op3,
    output logic [WIDTH-1:0]              op4,
    output logic                          out_valid,
    output logic [CNT_W-1:0]              quad_cnt
);

    logic drain;

    // A quad leaves when the consumer takes a valid quad
    assign drain = out_valid && out_ready;

    // Load a new quad, hold it under backpressure, count deliveries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1       <= '0;
            op2       <= '0;
            op3       <= '0;
            op4       <= '0;
            out_valid <= 1'b0;
            quad_cnt  <= '0;
        end else begin
            if (load) begin
                op1       <= load_data[0*WIDTH +: WIDTH];
                op2       <= load_data[1*WIDTH +: WIDTH];
                op3       <= load_data[2*WIDTH +: WIDTH];
                op4       <= load_data[3*WIDTH +: WIDTH];
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) begin
                quad_cnt <= quad_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/operand_gather.sv
// Groups a serial operand stream into quads for the 4-input arithmetic stage.
module operand_gather
    import operand_gather_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WIDTH-1:0]  op1,
    output logic [WIDTH-1:0]  op2,
    output logic [WIDTH-1:0]  op3,
    output logic [WIDTH-1:0]  op4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [CNT_W-1:0]  quad_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    col_state_e                      state;
    logic [PTR_W-1:0]                ptr;
    logic [WIDTH-1:0]                collect [QUAD_WORDS];

    logic                            accept;
    logic                            drain;
    logic                            frame_err;
    logic                            quad_done;
    logic                            load_direct;
    logic                            load_hold;
    logic                            load;
    logic [QUAD_WORDS*WIDTH-1:0]     load_data;

    // Words are refused only while a finished quad is parked
    assign in_ready = (state == COLLECT);

    // Handshake decode and selection of the quad handed to the output register
    always_comb begin
        accept      = 1'b0;
        drain       = 1'b0;
        frame_err   = 1'b0;
        quad_done   = 1'b0;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        load        = 1'b0;
        load_data   = '0;

        accept      = in_valid && in_ready;
        drain       = out_valid && out_ready;
        frame_err   = accept && in_last && (ptr != PTR_LAST);
        quad_done   = accept && !frame_err && (ptr == PTR_LAST);
        load_direct = quad_done && (!out_valid || out_ready);
        load_hold   = (state == HOLD) && drain;
        load        = load_direct || load_hold;

        if (load_direct) begin
            load_data = {in_data, collect[2], collect[1], collect[0]};
        end else begin
            load_data = {collect[3], collect[2], collect[1], collect[0]};
        end
    end

    // Collector FSM: word placement, framing check, parking a quad under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT;
            ptr     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            for (int i = 0; i < int'(QUAD_WORDS); i++) begin
                collect[i] <= '0;
            end
        end else begin
            err <= frame_err;
            if (frame_err) begin
                ptr <= '0;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end else if (accept) begin
                collect[ptr] <= in_data;
                ptr          <= ptr + PTR_W'(1);
                if (quad_done && !load_direct) begin
                    state <= HOLD;
                end
            end
            if (load_hold) begin
                state <= COLLECT;
            end
        end
    end

    gather_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .op4       (op4),
        .out_valid (out_valid),
        .quad_cnt  (quad_cnt)
    );

endmodule
